pwm_audio_sched: RTL and testbench

Sample scheduler for the PWM audio path. Shares the single PWM audio output between two sample producers: channel 0 (speech playback) and channel 1 (system alert/tone). Sits between the producers and the PWM modulator, and is paced by the sample-rate `tick` and sub-sample `s_tick` strobes from the PWM frequency generator. Arbitrates ownership at sample boundaries, reports underruns, and ramps the output to midscale when playback stops.

---
 rtl/pwm_audio_pkg.sv | 17 +
 rtl/pwm_sample_slot.sv | 45 ++++
 rtl/pwm_audio_sched.sv | 164 ++++++++++++++++
 tb/tb_pwm_audio_sched.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/pwm_audio_pkg.sv
// Shared types and constants for the PWM audio sample scheduler.
// State codes match the owner encodings so the owner output is a direct decode.
package pwm_audio_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CH0  = 2'b01,
        CH1  = 2'b10
    } sched_state_t;

    localparam logic [1:0] OWNER_IDLE = 2'b00;
    localparam logic [1:0] OWNER_CH0  = 2'b01;
    localparam logic [1:0] OWNER_CH1  = 2'b10;

    localparam logic [7:0] DEFAULT_SILENCE = 8'h80;

endpackage

// File: rtl/pwm_sample_slot.sv
// One-deep sample buffer between a producer and the scheduler.
// It is emptied only by the scheduler's consume strobe.
module pwm_sample_slot #(
    parameter int unsigned SAMPLE_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SAMPLE_W-1:0] in_data,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                consume,
    output logic                full,
    output logic [SAMPLE_W-1:0] data
);

    logic                full_q, full_d;
    logic [SAMPLE_W-1:0] data_q, data_d;

    assign in_ready = ~full_q & ~rst;
    assign full     = full_q;
    assign data     = data_q;

    // A transfer and a consume never coincide: ready is low while the slot is full.
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (consume) begin
            full_d = 1'b0;
        end else if (in_valid && in_ready) begin
            full_d = 1'b1;
            data_d = in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/pwm_audio_sched.sv
// Shares the PWM audio output between speech (ch0) and alert (ch1) producers,
// switching owner on sample ticks and fading to midscale when idle.
module pwm_audio_sched
    import pwm_audio_pkg::*;
#(
    parameter int unsigned         SAMPLE_W   = 8,
    parameter logic [SAMPLE_W-1:0] SILENCE    = DEFAULT_SILENCE,
    parameter int unsigned         MUTE_TICKS = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick,
    input  logic                s_tick,
    input  logic [SAMPLE_W-1:0] req0_data,
    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic [SAMPLE_W-1:0] req1_data,
    input  logic                req1_valid,
    output logic                req1_ready,
    output logic [SAMPLE_W-1:0] sample,
    output logic                sample_stb,
    output logic [1:0]          owner,
    output logic                underrun
);

    localparam int unsigned MissW = $clog2(MUTE_TICKS + 1);
    localparam logic [MissW-1:0] MissLast = MissW'(MUTE_TICKS - 1);

    sched_state_t        state_q, state_d;
    logic [MissW-1:0]    miss_q, miss_d;
    logic [SAMPLE_W-1:0] sample_q, sample_d;
    logic                stb_q, stb_d;
    logic                und_q, und_d;

    logic                full0, full1, consume0, consume1;
    logic [SAMPLE_W-1:0] data0, data1;
    logic                do_underrun, do_fade;

    pwm_sample_slot #(
        .SAMPLE_W (SAMPLE_W)
    ) u_slot0 (
        .clk      (clk),
        .rst      (rst),
        .in_data  (req0_data),
        .in_valid (req0_valid),
        .in_ready (req0_ready),
        .consume  (consume0),
        .full     (full0),
        .data     (data0)
    );

    pwm_sample_slot #(
        .SAMPLE_W (SAMPLE_W)
    ) u_slot1 (
        .clk      (clk),
        .rst      (rst),
        .in_data  (req1_data),
        .in_valid (req1_valid),
        .in_ready (req1_ready),
        .consume  (consume1),
        .full     (full1),
        .data     (data1)
    );

    // Arbitration decision; tick takes precedence over a coincident s_tick.
    always_comb begin
        state_d     = state_q;
        consume0    = 1'b0;
        consume1    = 1'b0;
        do_underrun = 1'b0;
        do_fade     = 1'b0;
        if (tick) begin
            unique case (state_q)
                IDLE: begin
                    if (full1) begin
                        state_d  = CH1;
                        consume1 = 1'b1;
                    end else if (full0) begin
                        state_d  = CH0;
                        consume0 = 1'b1;
                    end else begin
                        do_fade = 1'b1;
                    end
                end
                CH0: begin
                    if (full1) begin
                        state_d  = CH1;
                        consume1 = 1'b1;
                    end else if (full0) begin
                        consume0 = 1'b1;
                    end else begin
                        do_underrun = 1'b1;
                    end
                end
                CH1: begin
                    if (full1) begin
                        consume1 = 1'b1;
                    end else begin
                        do_underrun = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (s_tick && state_q == IDLE) begin
            do_fade = 1'b1;
        end
    end

    always_comb begin
        miss_d   = miss_q;
        sample_d = sample_q;
        stb_d    = 1'b0;
        und_d    = 1'b0;
        if (consume0 || consume1) begin
            sample_d = consume1 ? data1 : data0;
            stb_d    = 1'b1;
            miss_d   = '0;
        end else if (do_underrun) begin
            und_d = 1'b1;
            if (miss_q >= MissLast) begin
                miss_d = '0;
            end else begin
                miss_d = miss_q + MissW'(1);
            end
        end else if (do_fade) begin
            if (sample_q > SILENCE) begin
                sample_d = sample_q - SAMPLE_W'(1);
            end else if (sample_q < SILENCE) begin
                sample_d = sample_q + SAMPLE_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            miss_q   <= '0;
            sample_q <= SILENCE;
            stb_q    <= 1'b0;
            und_q    <= 1'b0;
        end else begin
            // The release decision needs the pre-increment count, so it lives here.
            state_q  <= (do_underrun && miss_q >= MissLast) ? IDLE : state_d;
            miss_q   <= miss_d;
            sample_q <= sample_d;
            stb_q    <= stb_d;
            und_q    <= und_d;
        end
    end

    always_comb begin
        owner = OWNER_IDLE;
        unique case (state_q)
            CH0:     owner = OWNER_CH0;
            CH1:     owner = OWNER_CH1;
            default: owner = OWNER_IDLE;
        endcase
    end

    assign sample     = sample_q;
    assign sample_stb = stb_q;
    assign underrun   = und_q;

endmodule

// File: tb/tb_pwm_audio_sched.sv
// Directed-vector bench for pwm_audio_sched with MUTE_TICKS = 4.
module tb_pwm_audio_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       s_tick = 1'b0;
    logic [7:0] req0_data = 8'h00;
    logic       req0_valid = 1'b0;
    logic       req0_ready;
    logic [7:0] req1_data = 8'h00;
    logic       req1_valid = 1'b0;
    logic       req1_ready;
    logic [7:0] sample;
    logic       sample_stb;
    logic [1:0] owner;
    logic       underrun;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pwm_audio_sched #(
        .SAMPLE_W   (8),
        .SILENCE    (8'h80),
        .MUTE_TICKS (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .s_tick     (s_tick),
        .req0_data  (req0_data),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req1_data  (req1_data),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .sample     (sample),
        .sample_stb (sample_stb),
        .owner      (owner),
        .underrun   (underrun)
    );

    typedef struct {
        logic       tk;
        logic       st;
        logic       v0;
        logic [7:0] d0;
        logic       v1;
        logic [7:0] d1;
        logic [7:0] e_sample;
        logic       e_stb;
        logic [1:0] e_owner;
        logic       e_und;
        logic       e_r0;
        logic       e_r1;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic tk, input logic st, input logic v0, input logic [7:0] d0,
                       input logic v1, input logic [7:0] d1, input logic [7:0] es,
                       input logic estb, input logic [1:0] eo, input logic eu,
                       input logic er0, input logic er1);
        vec_t v;
        v.tk = tk; v.st = st; v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1;
        v.e_sample = es; v.e_stb = estb; v.e_owner = eo; v.e_und = eu;
        v.e_r0 = er0; v.e_r1 = er1;
        vecs.push_back(v);
    endtask

    task automatic check(input string nm, input logic [7:0] es, input logic estb,
                         input logic [1:0] eo, input logic eu, input logic er0,
                         input logic er1);
        n_vec++;
        if ({sample, sample_stb, owner, underrun, req0_ready, req1_ready} !==
            {es, estb, eo, eu, er0, er1}) begin
            n_bad++;
            $display("FAIL %s: got sample=%h stb=%b owner=%b und=%b r0=%b r1=%b, want sample=%h stb=%b owner=%b und=%b r0=%b r1=%b",
                     nm, sample, sample_stb, owner, underrun, req0_ready, req1_ready,
                     es, estb, eo, eu, er0, er1);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //   tk st v0 d0     v1 d1     sample stb own    und r0 r1
        add(0, 0, 1, 8'h10, 0, 8'h00, 8'h80, 0, 2'b00, 0, 0, 1); // v0 load ch0
        add(1, 0, 1, 8'h99, 0, 8'h00, 8'h10, 1, 2'b01, 0, 1, 1); // v1 play, no xfer
        add(0, 0, 0, 8'h00, 0, 8'h00, 8'h10, 0, 2'b01, 0, 1, 1);
        add(0, 0, 1, 8'h20, 0, 8'h00, 8'h10, 0, 2'b01, 0, 0, 1);
        add(0, 0, 1, 8'h55, 1, 8'hF0, 8'h10, 0, 2'b01, 0, 0, 0); // v4 full slot ignores 55
        add(1, 0, 0, 8'h00, 0, 8'h00, 8'hF0, 1, 2'b10, 0, 0, 1); // v5 preempt
        add(1, 0, 0, 8'h00, 0, 8'h00, 8'hF0, 0, 2'b10, 1, 0, 1);
        add(1, 0, 0, 8'h00, 0, 8'h00, 8'hF0, 0, 2'b10, 1, 0, 1);
        add(1, 0, 0, 8'h00, 0, 8'h00, 8'hF0, 0, 2'b10, 1, 0, 1);
        add(1, 0, 0, 8'h00, 0, 8'h00, 8'hF0, 0, 2'b00, 1, 0, 1); // v9 release
        add(1, 0, 0, 8'h00, 0, 8'h00, 8'h20, 1, 2'b01, 0, 1, 1); // v10 ch0 resumes 20
        add(1, 0, 0, 8'h00, 0, 8'h00, 8'h20, 0, 2'b01, 1, 1, 1);
        add(0, 1, 0, 8'h00, 0, 8'h00, 8'h20, 0, 2'b01, 0, 1, 1); // v12 no fade while owned
        add(1, 0, 0, 8'h00, 0, 8'h00, 8'h20, 0, 2'b01, 1, 1, 1);
        add(1, 0, 0, 8'h00, 0, 8'h00, 8'h20, 0, 2'b01, 1, 1, 1);
        add(1, 0, 0, 8'h00, 0, 8'h00, 8'h20, 0, 2'b00, 1, 1, 1);
        add(0, 1, 0, 8'h00, 0, 8'h00, 8'h21, 0, 2'b00, 0, 1, 1); // v16 fade up
        add(1, 0, 0, 8'h00, 0, 8'h00, 8'h22, 0, 2'b00, 0, 1, 1);
        add(1, 1, 0, 8'h00, 0, 8'h00, 8'h23, 0, 2'b00, 0, 1, 1); // v18 single step
        add(0, 0, 1, 8'h84, 0, 8'h00, 8'h23, 0, 2'b00, 0, 0, 1);
        add(1, 0, 0, 8'h00, 0, 8'h00, 8'h84, 1, 2'b01, 0, 1, 1);
        add(1, 0, 0, 8'h00, 0, 8'h00, 8'h84, 0, 2'b01, 1, 1, 1);
        add(1, 0, 0, 8'h00, 0, 8'h00, 8'h84, 0, 2'b01, 1, 1, 1);
        add(1, 0, 0, 8'h00, 0, 8'h00, 8'h84, 0, 2'b01, 1, 1, 1);
        add(1, 0, 0, 8'h00, 0, 8'h00, 8'h84, 0, 2'b00, 1, 1, 1);
        add(0, 1, 0, 8'h00, 0, 8'h00, 8'h83, 0, 2'b00, 0, 1, 1); // v25 fade down
        add(0, 1, 0, 8'h00, 0, 8'h00, 8'h82, 0, 2'b00, 0, 1, 1);
        add(0, 1, 0, 8'h00, 0, 8'h00, 8'h81, 0, 2'b00, 0, 1, 1);
        add(0, 1, 0, 8'h00, 0, 8'h00, 8'h80, 0, 2'b00, 0, 1, 1);
        add(0, 1, 0, 8'h00, 0, 8'h00, 8'h80, 0, 2'b00, 0, 1, 1); // v29 settled
        add(1, 0, 0, 8'h00, 0, 8'h00, 8'h80, 0, 2'b00, 0, 1, 1);
        add(0, 0, 1, 8'h11, 1, 8'h22, 8'h80, 0, 2'b00, 0, 0, 0);
        add(1, 0, 0, 8'h00, 0, 8'h00, 8'h22, 1, 2'b10, 0, 0, 1); // v32 ch1 wins from idle
        add(0, 0, 0, 8'h00, 1, 8'h33, 8'h22, 0, 2'b10, 0, 0, 0);
        add(1, 0, 0, 8'h00, 0, 8'h00, 8'h33, 1, 2'b10, 0, 0, 1); // v34 ch0 cannot preempt
        add(0, 0, 0, 8'h00, 1, 8'h44, 8'h33, 0, 2'b10, 0, 0, 0);

        // Reset held for three cycles; ready must stay low while rst is high.
        rst = 1'b1;
        step();
        check("rst_c1", 8'h80, 0, 2'b00, 0, 0, 0);
        step();
        step();
        check("rst_c3", 8'h80, 0, 2'b00, 0, 0, 0);
        rst = 1'b0;
        step();
        check("rst_release", 8'h80, 0, 2'b00, 0, 1, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            tick       = vecs[i].tk;
            s_tick     = vecs[i].st;
            req0_valid = vecs[i].v0;
            req0_data  = vecs[i].d0;
            req1_valid = vecs[i].v1;
            req1_data  = vecs[i].d1;
            step();
            check($sformatf("vec%0d", i), vecs[i].e_sample, vecs[i].e_stb, vecs[i].e_owner,
                  vecs[i].e_und, vecs[i].e_r0, vecs[i].e_r1);
        end
        tick = 1'b0; s_tick = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;

        // Reset while ch1 owns with both slots full: no fade, slots discarded.
        rst = 1'b1;
        step();
        check("midrst", 8'h80, 0, 2'b00, 0, 0, 0);
        rst = 1'b0;
        step();
        check("midrst_slots_empty", 8'h80, 0, 2'b00, 0, 1, 1);
        tick = 1'b1;
        step();
        tick = 1'b0;
        check("midrst_tick_no_stb", 8'h80, 0, 2'b00, 0, 1, 1);
        step();
        check("midrst_idle", 8'h80, 0, 2'b00, 0, 1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running, want finished");
        $fatal(1);
    end

endmodule
